id_stage: RTL and testbench

//  Instruction-decode stage: consumer end of the fetch interface. Accepts 17-bit instructions over valid/ready,

---
 rtl/id_pkg.sv | 49 ++++
 rtl/id_skid_buf.sv | 24 ++
 rtl/id_stage.sv | 82 ++++++++
 tb/tb_id_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// id_pkg: opcode enum, instruction field map, decoded bundle type and decode function for id_stage.
package id_pkg;

  localparam int ID_INST_LEN = 17;
  localparam int ID_DATA_W   = 16;

  localparam int OP_HI  = 16;
  localparam int OP_LO  = 13;
  localparam int RD_HI  = 12;
  localparam int RD_LO  = 9;
  localparam int RS1_HI = 8;
  localparam int RS1_LO = 5;
  localparam int RS2_HI = 4;
  localparam int RS2_LO = 1;
  localparam int IMM_HI = 4;
  localparam int IMM_LO = 0;
  localparam int IMM_W  = IMM_HI - IMM_LO + 1;

  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
    OP_ADDI, OP_LD, OP_ST, OP_BEQ, OP_HALT
  } op_e;

  localparam logic [3:0] OP_LAST_LEGAL = 4'd10;

  typedef struct packed {
    op_e                  op;
    logic [3:0]           rd;
    logic [3:0]           rs1;
    logic [3:0]           rs2;
    logic [ID_DATA_W-1:0] imm;
  } id_bundle_t;

  function automatic logic is_illegal(input logic [ID_INST_LEN-1:0] inst);
    return inst[OP_HI:OP_LO] > OP_LAST_LEGAL;
  endfunction

  // Illegal opcodes collapse to an all-zero bundle, which reads as a plain NOP.
  function automatic id_bundle_t decode(input logic [ID_INST_LEN-1:0] inst);
    id_bundle_t b;
    b.op  = op_e'(inst[OP_HI:OP_LO]);
    b.rd  = inst[RD_HI:RD_LO];
    b.rs1 = inst[RS1_HI:RS1_LO];
    b.rs2 = inst[RS2_HI:RS2_LO];
    b.imm = {{(ID_DATA_W-IMM_W){inst[IMM_HI]}}, inst[IMM_HI:IMM_LO]};
    return is_illegal(inst) ? '0 : b;
  endfunction

endpackage

// File: rtl/id_skid_buf.sv
// id_skid_buf: one-entry holding register for a decoded bundle, with a full flag.
import id_pkg::*;

module id_skid_buf (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  id_bundle_t din,
  output id_bundle_t dout,
  output logic       full
);

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      dout <= '0;
    end else begin
      full <= push | (full & ~pop);
      if (push) dout <= din;
    end
  end

endmodule

// File: rtl/id_stage.sv
// id_stage: valid/ready instruction decode with registered output and one-entry skid buffer.
// Optional build macro ID_ILLEGAL_TRAP_EN traps illegal opcodes instead of forwarding them as NOP.
import id_pkg::*;

module id_stage #(
  parameter int INST_LEN = ID_INST_LEN,
  parameter int DATA_W   = ID_DATA_W,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [INST_LEN-1:0] in_inst,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          out_op,
  output logic [3:0]          out_rd,
  output logic [3:0]          out_rs1,
  output logic [3:0]          out_rs2,
  output logic [DATA_W-1:0]   out_imm,
  output logic                halted,
  output logic                err,
  output logic [CNT_W-1:0]    dec_cnt
);

  id_bundle_t bundle, skid_q, in_dec;
  logic skid_full, halt_seen, accept, fwd, drain, load_out;

  assign in_dec   = decode(in_inst);
  assign in_ready = !skid_full && !halt_seen && !err;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;
  assign load_out = !out_valid || out_ready;

`ifdef ID_ILLEGAL_TRAP_EN
  logic err_q;
  assign fwd = accept && !is_illegal(in_inst);
  assign err = err_q;
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_q | (accept && is_illegal(in_inst));
  end
`else
  assign fwd = accept;
  assign err = 1'b0;
`endif

  // The skid only fills while the output is held; it always empties first on a drain.
  id_skid_buf u_skid (
    .clk  (clk),
    .rst  (rst),
    .push (fwd && !load_out),
    .pop  (load_out && skid_full),
    .din  (in_dec),
    .dout (skid_q),
    .full (skid_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      bundle    <= '0;
      halt_seen <= 1'b0;
      halted    <= 1'b0;
      dec_cnt   <= '0;
    end else begin
      if (load_out) out_valid <= skid_full || fwd;
      if (load_out && (skid_full || fwd)) bundle <= skid_full ? skid_q : in_dec;
      halt_seen <= halt_seen | (accept && in_dec.op == OP_HALT);
      halted    <= halted | (drain && bundle.op == OP_HALT);
      if (drain) dec_cnt <= dec_cnt + 1'b1;
    end
  end

  assign out_op  = bundle.op;
  assign out_rd  = bundle.rd;
  assign out_rs1 = bundle.rs1;
  assign out_rs2 = bundle.rs2;
  assign out_imm = bundle.imm;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed scoreboard bench for id_stage; honours ID_ILLEGAL_TRAP_EN when defined.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, in_ready, out_valid, halted, err;
  logic [16:0] in_inst;
  logic [3:0]  out_op, out_rd, out_rs1, out_rs2;
  logic [15:0] out_imm;
  logic [7:0]  dec_cnt;

  id_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_inst(in_inst), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm), .halted(halted),
    .err(err), .dec_cnt(dec_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op, rd, rs1, rs2;
    logic [15:0] imm;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic last_acc;

  function automatic logic [16:0] enc(input logic [3:0] op, rd, rs1, rs2, input logic b0);
    return {op, rd, rs1, rs2, b0};
  endfunction

  function automatic exp_t model(input logic [16:0] i);
    exp_t e;
    if (i[16:13] > 4'd10) e = '{4'd0, 4'd0, 4'd0, 4'd0, 16'd0};
    else e = '{i[16:13], i[12:9], i[8:5], i[4:1], {{11{i[4]}}, i[4:0]}};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: score the drain and accept that happen at the coming edge, then move to the next negedge.
  task automatic step();
    exp_t e;
    #1;
    if (out_valid && out_ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("op",  32'(out_op),  32'(e.op));
        chk("rd",  32'(out_rd),  32'(e.rd));
        chk("rs1", 32'(out_rs1), 32'(e.rs1));
        chk("rs2", 32'(out_rs2), 32'(e.rs2));
        chk("imm", 32'(out_imm), 32'(e.imm));
      end
    end
    last_acc = in_valid && in_ready;
    if (last_acc) begin
`ifdef ID_ILLEGAL_TRAP_EN
      if (in_inst[16:13] <= 4'd10) sb.push_back(model(in_inst));
`else
      sb.push_back(model(in_inst));
`endif
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [16:0] w);
    in_valid = 1'b1;
    in_inst  = w;
    for (int k = 0; k < 20; k++) begin
      step();
      if (last_acc) break;
    end
    chk("send_accepted", 32'(last_acc), 32'd1);
    in_valid = 1'b0;
    in_inst  = 'x;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    in_inst   = 'x;
    out_ready = 1'b1;
    for (int k = 0; k < 10 && (sb.size() != 0 || out_valid); k++) step();
    chk("drained_sb", 32'(sb.size()), 32'd0);
    chk("drained_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_inst  = 'x;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_inst = 'x;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_dec_cnt", 32'(dec_cnt), 32'd0);
    chk("rst_op", 32'(out_op), 32'd0);
    chk("rst_imm", 32'(out_imm), 32'd0);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // 1: ADD r1,r2,r3 then back-to-back stream
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_inst   = enc(4'd1, 4'd1, 4'd2, 4'd3, 1'b0);
    step();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_op", 32'(out_op), 32'd1);
    chk("t1_rd", 32'(out_rd), 32'd1);
    chk("t1_rs1", 32'(out_rs1), 32'd2);
    chk("t1_rs2", 32'(out_rs2), 32'd3);
    for (int i = 0; i < 4; i++) begin
      in_inst = enc(4'(i + 1), 4'(i), 4'(i + 1), 4'(i + 2), 1'(i));
      chk("t1_no_gap_valid", 32'(out_valid), 32'd1);
      chk("t1_no_gap_ready", 32'(in_ready), 32'd1);
      step();
    end

    // 2: immediate sign extension
    in_inst = enc(4'd6, 4'd4, 4'd5, 4'b1011, 1'b0);
    step();
    chk("t2_imm_neg", 32'(out_imm), 32'h0000FFF6);
    in_inst = enc(4'd6, 4'd4, 4'd5, 4'b0101, 1'b0);
    step();
    chk("t2_imm_pos", 32'(out_imm), 32'h0000000A);
    drain();

    // 3: three-cycle output stall fills the skid
    in_valid = 1'b1;
    in_inst  = enc(4'd2, 4'd1, 4'd1, 4'd1, 1'b0);
    step();
    out_ready = 1'b0;
    in_inst   = enc(4'd3, 4'd2, 4'd2, 4'd2, 1'b0);
    step();
    chk("t3_ready_low", 32'(in_ready), 32'd0);
    chk("t3_head_op", 32'(out_op), 32'd2);
    in_inst = enc(4'd4, 4'd3, 4'd3, 4'd3, 1'b0);
    step();
    step();
    chk("t3_ready_still_low", 32'(in_ready), 32'd0);
    chk("t3_head_stable", 32'(out_op), 32'd2);
    out_ready = 1'b1;
    send(enc(4'd4, 4'd3, 4'd3, 4'd3, 1'b0));
    drain();

    // 4: HALT blocks further input
    do_reset();
    out_ready = 1'b1;
    send(enc(4'd0, 4'd0, 4'd0, 4'd0, 1'b0));
    send(enc(4'd10, 4'd0, 4'd0, 4'd0, 1'b0));
    chk("t4_ready_after_halt", 32'(in_ready), 32'd0);
    chk("t4_halted_pending", 32'(halted), 32'd0);
    in_valid = 1'b1;
    in_inst  = enc(4'd1, 4'd1, 4'd2, 4'd3, 1'b0);
    step();
    chk("t4_halted", 32'(halted), 32'd1);
    chk("t4_dec_cnt", 32'(dec_cnt), 32'd2);
    repeat (3) step();
    chk("t4_add_blocked", 32'(out_valid), 32'd0);
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);
    chk("t4_dec_cnt_hold", 32'(dec_cnt), 32'd2);

    // 5: illegal opcode 13
    do_reset();
    out_ready = 1'b1;
    send(enc(4'd13, 4'd5, 4'd6, 4'd7, 1'b1));
`ifdef ID_ILLEGAL_TRAP_EN
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_ready", 32'(in_ready), 32'd0);
    chk("t5_not_fwd", 32'(out_valid), 32'd0);
`else
    chk("t5_err", 32'(err), 32'd0);
    chk("t5_ready", 32'(in_ready), 32'd1);
    chk("t5_nop_valid", 32'(out_valid), 32'd1);
    chk("t5_nop_op", 32'(out_op), 32'd0);
    chk("t5_nop_rd", 32'(out_rd), 32'd0);
    chk("t5_nop_imm", 32'(out_imm), 32'd0);
`endif
    drain();

    // 6: reset with skid full, then counter wrap
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = enc(4'd1, 4'd1, 4'd1, 4'd1, 1'b0);
    step();
    in_inst = enc(4'd2, 4'd2, 4'd2, 4'd2, 1'b0);
    step();
    chk("t6_skid_full", 32'(in_ready), 32'd0);
    do_reset();
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_dec_cnt", 32'(dec_cnt), 32'd0);
    chk("t6_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_inst = {4'($urandom_range(0, 9)), 13'($urandom)};
      step();
    end
    chk("t6_cnt_255", 32'(dec_cnt), 32'd255);
    in_valid = 1'b0;
    in_inst  = 'x;
    step();
    chk("t6_cnt_wrap", 32'(dec_cnt), 32'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
